// File: rtl/vga_pkg.sv
// Shared constants, pixel layout and capture-state encoding for the VGA frame capture block.
package vga_pkg;

    localparam int VGA_WIDTH  = 640;
    localparam int VGA_HEIGHT = 480;
    localparam int SRC_WIDTH  = 160;
    localparam int SRC_HEIGHT = 120;

    typedef struct packed {
        logic [9:0] r;
        logic [9:0] g;
        logic [9:0] b;
    } pixel_t;

    typedef enum logic [1:0] {
        WAIT_SOP = 2'd0,
        CAPTURE  = 2'd1,
        HOLD     = 2'd2
    } capture_state_e;

    // Keep the top four bits of each channel for the 12-bit store word.
    function automatic logic [11:0] pack_pixel(input pixel_t p);
        return {p.r[9:6], p.g[9:6], p.b[9:6]};
    endfunction

endpackage

// File: rtl/vga_frame_store.sv
// Simple dual-port decimated frame store: one write port, one registered read port (read-old on collision).
module vga_frame_store
    import vga_pkg::*;
#(
    parameter int DEPTH = SRC_WIDTH * SRC_HEIGHT
) (
    input  logic        clk,
    input  logic        wr_en,
    input  logic [14:0] wr_addr,
    input  logic [11:0] wr_data,
    input  logic [14:0] rd_addr,
    output logic [11:0] rd_data
);

    logic [11:0] mem [0:DEPTH-1];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
        rd_data <= mem[rd_addr];
    end

endmodule

// File: rtl/vga_frame_capture.sv
// Avalon-ST VGA frame grabber that decimates each frame into a small store.
// Optional statistics counters are built only when VGA_CAPTURE_STATS_EN is defined.
module vga_frame_capture
    import vga_pkg::*;
#(
    parameter int VGA_WIDTH   = vga_pkg::VGA_WIDTH,
    parameter int VGA_HEIGHT  = vga_pkg::VGA_HEIGHT,
    parameter int SCALE_SHIFT = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [29:0] data,
    input  logic        startofpacket,
    input  logic        endofpacket,
    input  logic        valid,
    output logic        ready,
    input  logic        single_shot,
    input  logic        arm,
    input  logic [14:0] rd_addr,
    output logic [11:0] rd_data,
    output logic        frame_done,
    output logic        frame_valid,
    output logic        err,
    output logic [15:0] frame_count,
    output logic [15:0] error_count
);

    localparam int         DST_WIDTH = VGA_WIDTH >> SCALE_SHIFT;
    localparam int         DST_DEPTH = DST_WIDTH * (VGA_HEIGHT >> SCALE_SHIFT);
    localparam logic [9:0] X_LAST    = 10'(VGA_WIDTH - 1);
    localparam logic [8:0] Y_LAST    = 9'(VGA_HEIGHT - 1);
    localparam logic [9:0] X_MASK    = 10'((1 << SCALE_SHIFT) - 1);
    localparam logic [8:0] Y_MASK    = 9'((1 << SCALE_SHIFT) - 1);

    capture_state_e state;
    logic [9:0]     x;
    logic [8:0]     y;
    logic           out_en;
    logic           accept;
    logic           at_last;
    logic           cap_beat;
    logic           good_evt;
    logic           restart_evt;
    logic           bad_evt;
    logic [9:0]     px_x;
    logic [8:0]     px_y;
    logic           wr_en;
    logic [14:0]    wr_addr;
    pixel_t         pix;

    // out_en keeps ready low during reset and raises it on the first edge after release.
    assign ready    = out_en && (state != HOLD);
    assign accept   = valid && ready;
    assign at_last  = (x == X_LAST) && (y == Y_LAST);
    assign cap_beat = accept && (state == CAPTURE);

    assign good_evt    = cap_beat && at_last && endofpacket && !startofpacket;
    assign restart_evt = cap_beat && startofpacket && !endofpacket && !at_last;
    assign bad_evt     = (accept && (state == WAIT_SOP) && startofpacket && endofpacket) ||
                         (cap_beat && !good_evt && (startofpacket || endofpacket || at_last));

    // An SOP beat is always pixel 0, whether it opens a frame or restarts one.
    assign px_x    = startofpacket ? 10'd0 : x;
    assign px_y    = startofpacket ? 9'd0  : y;
    assign pix     = data;
    assign wr_en   = accept && ((state == CAPTURE) || startofpacket) &&
                     ((px_x & X_MASK) == 10'd0) && ((px_y & Y_MASK) == 9'd0);
    assign wr_addr = 15'(32'(px_y >> SCALE_SHIFT) * DST_WIDTH) + 15'(px_x >> SCALE_SHIFT);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= WAIT_SOP;
            x           <= '0;
            y           <= '0;
            out_en      <= 1'b0;
            frame_done  <= 1'b0;
            err         <= 1'b0;
            frame_valid <= 1'b0;
        end else begin
            out_en     <= 1'b1;
            frame_done <= good_evt;
            err        <= bad_evt;
            case (state)
                WAIT_SOP: begin
                    if (accept && startofpacket) begin
                        frame_valid <= 1'b0;
                        if (!endofpacket) begin
                            state <= CAPTURE;
                            x     <= 10'd1;
                            y     <= 9'd0;
                        end
                    end
                end
                CAPTURE: begin
                    if (good_evt) begin
                        frame_valid <= 1'b1;
                        state       <= single_shot ? HOLD : WAIT_SOP;
                        x           <= '0;
                        y           <= '0;
                    end else if (restart_evt) begin
                        x <= 10'd1;
                        y <= 9'd0;
                    end else if (bad_evt) begin
                        state <= WAIT_SOP;
                        x     <= '0;
                        y     <= '0;
                    end else if (cap_beat) begin
                        if (x == X_LAST) begin
                            x <= '0;
                            y <= y + 9'd1;
                        end else begin
                            x <= x + 10'd1;
                        end
                    end
                end
                HOLD: begin
                    if (arm) begin
                        state <= WAIT_SOP;
                    end
                end
                default: state <= WAIT_SOP;
            endcase
        end
    end

`ifdef VGA_CAPTURE_STATS_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            frame_count <= '0;
            error_count <= '0;
        end else begin
            if (good_evt) begin
                frame_count <= frame_count + 16'd1;
            end
            if (bad_evt && (error_count != 16'hFFFF)) begin
                error_count <= error_count + 16'd1;
            end
        end
    end
`else
    assign frame_count = '0;
    assign error_count = '0;
`endif

    vga_frame_store #(
        .DEPTH(DST_DEPTH)
    ) u_store (
        .clk     (clk),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (pack_pixel(pix)),
        .rd_addr (rd_addr),
        .rd_data (rd_data)
    );

endmodule

// File: tb/tb_vga_frame_capture.sv
// Self-checking bench for vga_frame_capture on a reduced 64x48 frame, with a read-back scoreboard.
module tb_vga_frame_capture;

    localparam int W  = 64;
    localparam int H  = 48;
    localparam int S  = 2;
    localparam int DW = W >> S;
    localparam int N  = W * H;

    logic        clk;
    logic        reset_n;
    logic [29:0] data;
    logic        startofpacket;
    logic        endofpacket;
    logic        valid;
    logic        ready;
    logic        single_shot;
    logic        arm;
    logic [14:0] rd_addr;
    logic [11:0] rd_data;
    logic        frame_done;
    logic        frame_valid;
    logic        err;
    logic [15:0] frame_count;
    logic [15:0] error_count;

    vga_frame_capture #(
        .VGA_WIDTH  (W),
        .VGA_HEIGHT (H),
        .SCALE_SHIFT(S)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .data         (data),
        .startofpacket(startofpacket),
        .endofpacket  (endofpacket),
        .valid        (valid),
        .ready        (ready),
        .single_shot  (single_shot),
        .arm          (arm),
        .rd_addr      (rd_addr),
        .rd_data      (rd_data),
        .frame_done   (frame_done),
        .frame_valid  (frame_valid),
        .err          (err),
        .frame_count  (frame_count),
        .error_count  (error_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [14:0] addr;
        logic [11:0] exp;
    } rd_vec_t;

    rd_vec_t     rd_tab [8];
    logic [11:0] exp_q [$];
    int          checks = 0;
    int          failures = 0;
    int          done_seen = 0;
    int          err_seen = 0;
    int          exp_fc = 0;
    int          exp_ec = 0;
    int          d0;
    int          e0;

    // Pulse counters, so sequences can check how many pulses a stretch of stimulus produced.
    always @(negedge clk) begin
        if (reset_n) begin
            if (frame_done === 1'b1) done_seen++;
            if (err === 1'b1) err_seen++;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Store word for a frame whose pixel at index i carries the value base+i.
    function automatic logic [11:0] model_px(input int addr, input int base);
        int          px;
        int          py;
        logic [29:0] v;
        py = (addr / DW) << S;
        px = (addr % DW) << S;
        v  = 30'(base + py * W + px);
        return {v[29:26], v[19:16], v[9:6]};
    endfunction

    task automatic beat(input bit sop, input bit eop, input logic [29:0] d);
        @(negedge clk);
        valid         = 1'b1;
        startofpacket = sop;
        endofpacket   = eop;
        data          = d;
    endtask

    task automatic idle();
        @(negedge clk);
        valid         = 1'b0;
        startofpacket = 1'b0;
        endofpacket   = 1'b0;
    endtask

    task automatic send_frame(input int base, input int nbeats, input bit with_eop);
        for (int i = 0; i < nbeats; i++) begin
            beat(i == 0, with_eop && (i == nbeats - 1), 30'(base + i));
        end
    endtask

    task automatic check_stats();
`ifdef VGA_CAPTURE_STATS_EN
        check("frame_count", {16'd0, frame_count}, exp_fc);
        check("error_count", {16'd0, error_count}, exp_ec);
`else
        check("frame_count", {16'd0, frame_count}, 32'd0);
        check("error_count", {16'd0, error_count}, 32'd0);
`endif
    endtask

    // Expected read data is queued when an address is driven and compared one cycle later.
    task automatic readback(input int base);
        logic [11:0] e;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (i > 0) begin
                e = exp_q.pop_front();
                check("rd_data", {20'd0, rd_data}, {20'd0, e});
            end
            rd_addr = rd_tab[i].addr;
            if (base == 0) exp_q.push_back(rd_tab[i].exp);
            else           exp_q.push_back(model_px(int'(rd_tab[i].addr), base));
        end
        @(negedge clk);
        e = exp_q.pop_front();
        check("rd_data", {20'd0, rd_data}, {20'd0, e});
    endtask

    initial begin
        int a_list [8] = '{0, 1, 15, 16, 161, 100, 17, 191};
        for (int i = 0; i < 8; i++) begin
            rd_tab[i].addr = 15'(a_list[i]);
            rd_tab[i].exp  = model_px(a_list[i], 0);
        end

        reset_n       = 1'b0;
        valid         = 1'b0;
        startofpacket = 1'b0;
        endofpacket   = 1'b0;
        data          = '0;
        single_shot   = 1'b0;
        arm           = 1'b0;
        rd_addr       = '0;

        repeat (3) @(negedge clk);
        check("reset_ready", ready, 0);
        check("reset_frame_done", frame_done, 0);
        check("reset_err", err, 0);
        check("reset_frame_valid", frame_valid, 0);
        check_stats();
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_release", ready, 1);

        // Junk before the first SOP is dropped, then a full good frame.
        d0 = done_seen;
        e0 = err_seen;
        for (int i = 0; i < 1000; i++) begin
            beat(1'b0, (i % 97) == 0, 30'($urandom));
        end
        send_frame(0, N, 1'b1);
        idle();
        check("frame_done_after_eop", frame_done, 1);
        check("frame_valid_good", frame_valid, 1);
        exp_fc++;
        idle();
        check("frame_done_one_cycle", frame_done, 0);
        check("done_pulses_first", done_seen - d0, 1);
        check("no_err_first", err_seen - e0, 0);
        check_stats();
        readback(0);

        // SOP overwrites address 0 while it is being read; then EOP arrives early at index 1000.
        @(negedge clk);
        rd_addr       = 15'd0;
        valid         = 1'b1;
        startofpacket = 1'b1;
        endofpacket   = 1'b0;
        data          = 30'd1000;
        beat(1'b0, 1'b0, 30'd1001);
        check("rd_old_on_collision", {20'd0, rd_data}, {20'd0, model_px(0, 0)});
        check("frame_valid_clear_on_sop", frame_valid, 0);
        beat(1'b0, 1'b0, 30'd1002);
        check("rd_new_after_write", {20'd0, rd_data}, {20'd0, model_px(0, 1000)});
        for (int i = 3; i < 1000; i++) begin
            beat(1'b0, 1'b0, 30'(1000 + i));
        end
        beat(1'b0, 1'b1, 30'd2000);
        idle();
        check("err_short_frame", err, 1);
        check("frame_valid_short", frame_valid, 0);
        check("ready_wait_sop", ready, 1);
        exp_ec++;
        check_stats();
        idle();
        check("err_one_cycle", err, 0);

        // SOP at index 500 restarts capture; the restarted frame completes normally.
        d0 = done_seen;
        e0 = err_seen;
        send_frame(5000, 500, 1'b0);
        send_frame(7000, N, 1'b1);
        idle();
        check("frame_done_after_restart", frame_done, 1);
        idle();
        check("err_pulses_restart", err_seen - e0, 1);
        check("done_pulses_restart", done_seen - d0, 1);
        exp_ec++;
        exp_fc++;
        check_stats();
        readback(7000);

        // Long frame, then a lone SOP+EOP beat.
        send_frame(0, N, 1'b0);
        idle();
        check("err_long_frame", err, 1);
        exp_ec++;
        beat(1'b1, 1'b1, 30'd0);
        idle();
        check("err_sop_eop", err, 1);
        check("ready_after_sop_eop", ready, 1);
        exp_ec++;
        check_stats();

        // Single-shot: the first frame parks the block in HOLD; the second is refused.
        single_shot = 1'b1;
        d0 = done_seen;
        send_frame(20000, N, 1'b1);
        idle();
        check("frame_done_single_shot", frame_done, 1);
        check("ready_low_in_hold", ready, 0);
        exp_fc++;
        send_frame(40000, N, 1'b1);
        idle();
        check("single_shot_one_done", done_seen - d0, 1);
        check("ready_still_low", ready, 0);
        check("frame_valid_hold", frame_valid, 1);
        readback(20000);
        @(negedge clk);
        arm = 1'b1;
        @(negedge clk);
        arm = 1'b0;
        check("ready_after_arm", ready, 1);
        single_shot = 1'b0;
        check_stats();

        // Reset in the middle of a frame, then a clean frame.
        e0 = err_seen;
        send_frame(0, 1000, 1'b0);
        @(negedge clk);
        reset_n = 1'b0;
        valid   = 1'b0;
        #1;
        check("midreset_ready", ready, 0);
        check("midreset_frame_done", frame_done, 0);
        check("midreset_err", err, 0);
        check("midreset_frame_valid", frame_valid, 0);
        exp_fc = 0;
        exp_ec = 0;
        check_stats();
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        check("ready_after_midreset", ready, 1);
        check("no_err_on_reset", err_seen - e0, 0);
        send_frame(9000, N, 1'b1);
        idle();
        check("frame_done_after_reset", frame_done, 1);
        exp_fc++;
        idle();
        check_stats();
        readback(9000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vga_frame_capture.md
VGA_FRAME_CAPTURE -- requirements
Module: vga_frame_capture

Interface
REQ-001 SHALL have parameters:
- VGA_WIDTH, 640, input frame width in pixels.
- VGA_HEIGHT, 480, input frame height in lines.
- SCALE_SHIFT, 2, log2 decimation factor per axis, giving a 160x120 store.

REQ-002 SHALL have ports:
- clk  in  1  sole clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- data  in  30  Avalon-ST pixel {R[29:20],G[19:10],B[9:0]}.
- startofpacket  in  1  first pixel of frame.
- endofpacket  in  1  last pixel of frame.
- valid  in  1  beat present.
- ready  out  1  sink can accept.
- single_shot  in  1  1 = stop after one good frame.
- arm  in  1  one-cycle pulse re-enabling capture in single-shot mode.
- rd_addr  in  15  store read address, 0..19199.
- rd_data  out  12  stored pixel {R4,G4,B4}, 1-cycle latency.
- frame_done  out  1  one-cycle pulse after a good frame.
- frame_valid  out  1  store holds a complete frame.
- err  out  1  one-cycle pulse on a malformed frame.
- frame_count  out  16  good frames, wraps.
- error_count  out  16  malformed frames, saturating.

Function
REQ-003 A beat SHALL be accepted when valid & ready are high on a clk edge; otherwise it is ignored.
REQ-004 The FSM SHALL have three states:
- WAIT_SOP: ready=1; non-SOP beats are discarded; an SOP beat is captured as pixel 0 and moves to CAPTURE.
- CAPTURE: ready=1; captures beats in order.
- HOLD: ready=0; waits for arm.
REQ-005 The pixel counter SHALL be 19 bits, split into x (0..VGA_WIDTH-1) and y (0..VGA_HEIGHT-1); x wraps to 0 and y increments at end of line.
REQ-006 An accepted beat with x[1:0]==0 and y[1:0]==0 SHALL write the store at (y>>2)*160+(x>>2) with {data[29:26],data[19:16],data[9:6]}; other beats are not written.
REQ-007 A beat with endofpacket at pixel index 307199 (good frame) SHALL:
- pulse frame_done for one cycle on the next edge;
- set frame_valid;
- go to HOLD if single_shot=1, else to WAIT_SOP.
REQ-008 A short frame (endofpacket before index 307199) SHALL pulse err and return to WAIT_SOP.
REQ-009 A long frame (index 307199 accepted without endofpacket) SHALL pulse err and return to WAIT_SOP.
REQ-010 An SOP beat in CAPTURE before index 307199 SHALL pulse err and restart capture with that beat as pixel 0.
REQ-011 frame_valid SHALL clear when an SOP beat is accepted in WAIT_SOP.
REQ-012 In HOLD, arm SHALL move the FSM to WAIT_SOP with ready=1 on the next cycle; arm is ignored in other states.
REQ-013 For a read and a write to the same address in the same cycle, rd_data SHALL return the old data.
REQ-014 A beat with both startofpacket and endofpacket SHALL be treated as a short frame (err).

Reset
REQ-015 While reset_n=0, outputs SHALL be:
- ready=0, frame_done=0, err=0, frame_valid=0;
- counters=0, state=WAIT_SOP.
Store contents are undefined.
REQ-016 Reset mid-frame SHALL abandon the frame without an err pulse; ready=1 on the first edge after release.

Configuration
REQ-017 With VGA_CAPTURE_STATS_EN defined, frame_count SHALL increment per good frame (wrapping) and error_count per err pulse (saturating at 65535).
REQ-018 Without VGA_CAPTURE_STATS_EN, frame_count and error_count SHALL be tied to 0 and no counter logic is instantiated.

Structure
REQ-019 Package vga_pkg SHALL hold:
- VGA_WIDTH, VGA_HEIGHT, SRC_WIDTH=160, SRC_HEIGHT=120;
- the pixel struct (r,g,b 10-bit);
- the capture-state enum {WAIT_SOP, CAPTURE, HOLD}.
REQ-020 The 19200x12 simple dual-port store SHALL be the sub-module vga_frame_store (one write port, one registered read port).

Verification
REQ-021 Send a full 640x480 frame whose pixel value equals index; expect:
- frame_done one cycle after EOP;
- rd_addr 161 gives the 12-bit value of pixel 2564.
REQ-022 Send 1000 non-SOP beats, then a good frame -> first 1000 beats dropped, one frame_done, err never asserted.
REQ-023 Send EOP at index 1000 -> err pulse, frame_valid=0, FSM in WAIT_SOP; error_count=1 if VGA_CAPTURE_STATS_EN is defined.
REQ-024 Set single_shot=1 and send two frames -> ready=0 after the first EOP, second frame not accepted; arm pulse -> ready=1 next cycle.
REQ-025 Send SOP at index 5000 -> err pulse; following 307200-beat frame is good.
REQ-026 Assert reset_n=0 at index 100000 -> all outputs at reset values; a frame after release captures normally.
